// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider).
// Optional MULDIV_FAST_MUL_EN: multiplies skip RUN and form the product combinationally in FIX.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned DW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] mcand_q;
  logic [DW-1:0]   acc_q;
  logic            neg_res_q;
  logic            neg_rem_q;
  logic            special_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, fast_go;
  logic [XLEN-1:0] mag_a, mag_b, spec_val;

  always_comb begin
    a_sgn    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn    = (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_sgn && rs1_data[XLEN-1];
    b_neg    = b_sgn && rs2_data[XLEN-1];
    mag_a    = a_neg ? -rs1_data : rs1_data;
    mag_b    = b_neg ? -rs2_data : rs2_data;
    div_zero = funct3[2] && (rs2_data == '0);
    div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    spec_val = '0;
    if (div_zero)
      spec_val = funct3[1] ? rs1_data : '1;
    else if (div_ovf)
      spec_val = funct3[1] ? '0 : rs1_data;
`ifdef MULDIV_FAST_MUL_EN
    fast_go  = !funct3[2];
`else
    fast_go  = 1'b0;
`endif
  end

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic [DW-1:0]   mul_next, div_next, step_d;
  logic            unused_diff;

  always_comb begin
    sum      = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {sum, acc_q[XLEN-1:1]};
    // Remainder is shifted one bit wider so the trial subtract never loses the carry-out.
    rem_sh   = acc_q[DW-1:XLEN-1];
    diff     = {1'b0, rem_sh} - {2'b00, mcand_q};
    div_next = diff[XLEN+1] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
    step_d   = op_q[2] ? div_next : mul_next;
  end

  assign unused_diff = diff[XLEN];

  logic [DW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, res_d;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod   = op_q[2] ? acc_q : DW'(mcand_q) * DW'(acc_q[XLEN-1:0]);
`else
    prod   = acc_q;
`endif
    prod_s = neg_res_q ? -prod : prod;
    quo_s  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = neg_rem_q ? -acc_q[DW-1:XLEN] : acc_q[DW-1:XLEN];
    res_d  = '0;
    if (special_q) begin
      res_d = acc_q[XLEN-1:0];
    end else begin
      case (op_q)
        3'b000:                 res_d = prod_s[XLEN-1:0];
        3'b001, 3'b010, 3'b011: res_d = prod_s[DW-1:XLEN];
        3'b100, 3'b101:         res_d = quo_s;
        default:                res_d = rem_s;
      endcase
    end
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              op_q      <= funct3;
              mcand_q   <= funct3[2] ? mag_b : mag_a;
              neg_res_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              cnt_q     <= CW'(XLEN);
              special_q <= div_zero || div_ovf;
              if (div_zero || div_ovf) begin
                acc_q   <= {{XLEN{1'b0}}, spec_val};
                state_q <= FIX;
              end else begin
                acc_q   <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
                state_q <= fast_go ? FIX : RUN;
              end
            end
          end
          RUN: begin
            acc_q <= step_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1))
              state_q <= FIX;
          end
          FIX: begin
            result_q <= res_d;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit; a scoreboard queue is checked by a done-driven monitor.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .SYS_clk  (clk),
    .SYS_reset(rst),
    .start    (start),
    .funct3   (f3),
    .rs1_data (a),
    .rs2_data (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MULLAT = 1;
`else
  localparam int MULLAT = 33;
`endif

  typedef struct packed {
    logic [31:0] res;
    int          due;
    int          id;
  } exp_t;

  exp_t q[$];
  int   next_id = 0;
  int   done_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation, on the expected edge.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 result=0x%08h, expected no done", result);
      end else begin
        e = q.pop_front();
        chk($sformatf("result[%0d]", e.id), result, e.res);
        chk($sformatf("done_edge[%0d]", e.id), 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic drive_start(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                             input logic [31:0] exp, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    f3 = f;
    a = aa;
    b = bb;
    if (push) begin
      e.res = exp;
      e.due = cyc + 1 + lat;
      e.id  = next_id;
      next_id++;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_e0", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                     input logic [31:0] exp, input int lat);
    drive_start(f, aa, bb, exp, lat, 1'b1);
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    bit seen;
    exp_t e;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;

    run(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MULLAT);
    run(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MULLAT);
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MULLAT);
    run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MULLAT);
    run(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run(3'b101, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 33);
    run(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run(3'b110, 32'd5,        32'd0,        32'd5,        1);
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // remu 100 % 7 with a stray start pulse sampled at E5
    drive_start(3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    f3 = 3'b000;
    a = 32'd2;
    b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // divu aborted by flush sampled at E10
    drive_start(3'b101, 32'd1000, 32'd3, 32'd0, 33, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    dc = done_cnt;
    repeat (40) @(negedge clk);
    chk("flush_no_done", 32'(done_cnt), 32'(dc));
    chk("flush_result_kept", result, 32'd2);

    // asynchronous reset in the middle of RUN
    drive_start(3'b000, 32'd5, 32'd6, 32'd0, MULLAT, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", {31'b0, busy}, 32'd0);
    chk("midrun_rst_done", {31'b0, done}, 32'd0);
    chk("midrun_rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // back-to-back: start held high through the done cycle of the first op
    @(negedge clk);
    start = 1'b1;
    f3 = 3'b000;
    a = 32'd3;
    b = 32'd4;
    e.res = 32'h0000000C;
    e.due = cyc + 1 + MULLAT;
    e.id  = next_id;
    next_id++;
    q.push_back(e);
    @(negedge clk);
    f3 = 3'b111;
    a = 32'd9;
    b = 32'd4;
    chk("b2b_busy1", {31'b0, busy}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_first_done_seen", {31'b0, seen}, 32'd1);
    if (seen) begin
      e.res = 32'd1;
      e.due = cyc + 1 + 33;
      e.id  = next_id;
      next_id++;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy2", {31'b0, busy}, 32'd1);
    end else begin
      start = 1'b0;
    end
    wait_drain();

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
